// File: rtl/lcd_fifo_drain_ctrl.sv
// Read-side sequencer: pops SOF-tagged RGB565 words from the pixel FIFO and drives 8080 LCD writes.
// Optional macro LCD_SOF_ERR_CNT_EN adds SOF_ERR_CNT, a saturating count of mid-frame SOF aborts.
module lcd_fifo_drain_ctrl #(
  parameter int unsigned H_PIX       = 320,
  parameter int unsigned V_LINES     = 240,
  parameter int unsigned WR_LOW_CYC  = 2,
  parameter int unsigned WR_HIGH_CYC = 2,
  parameter logic [7:0]  CMD_MEMWR   = 8'h2C,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        FIFO_EMPTY,
  input  logic [17:0] FIFO_Q,
  output logic        FIFO_RE,
  output logic        LCD_CS_N,
  output logic        LCD_DC,
  output logic        LCD_WR_N,
  output logic [15:0] LCD_D,
  output logic        FRAME_DONE,
  output logic        BUSY
`ifdef LCD_SOF_ERR_CNT_EN
  ,
  output logic [7:0]  SOF_ERR_CNT
`endif
);

  localparam int unsigned PW     = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int unsigned LW     = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int unsigned WR_MAX = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int unsigned CW     = (WR_MAX > 1) ? $clog2(WR_MAX) : 1;
  localparam int unsigned LATW   = 2;

  typedef enum logic [3:0] {
    IDLE, HUNT, CMD, WR_L, WR_H, FETCH, WAITQ, PIX, FDONE
  } state_t;

  state_t          state;
  logic [PW-1:0]   pix_cnt;
  logic [LW-1:0]   line_cnt;
  logic [CW-1:0]   cyc_cnt;
  logic [LATW-1:0] lat_cnt;
  logic [15:0]     held;
  logic            hunting;

  // Bit 16 of the FIFO word carries nothing for the LCD.
  logic unused_q16;
  assign unused_q16 = FIFO_Q[16];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      FIFO_RE    <= 1'b0;
      LCD_CS_N   <= 1'b1;
      LCD_DC     <= 1'b1;
      LCD_WR_N   <= 1'b1;
      LCD_D      <= '0;
      FRAME_DONE <= 1'b0;
      BUSY       <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      cyc_cnt    <= '0;
      lat_cnt    <= '0;
      held       <= '0;
      hunting    <= 1'b1;
`ifdef LCD_SOF_ERR_CNT_EN
      SOF_ERR_CNT <= '0;
`endif
    end else begin
      FIFO_RE    <= 1'b0;
      FRAME_DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          pix_cnt  <= '0;
          line_cnt <= '0;
          if (ENABLE) begin
            state   <= HUNT;
            BUSY    <= 1'b1;
            hunting <= 1'b1;
          end
        end
        // Both issue one read at a time; HUNT discards until SOF, FETCH feeds the frame.
        HUNT, FETCH: begin
          if (!ENABLE) begin
            state    <= IDLE;
            LCD_CS_N <= 1'b1;
            LCD_DC   <= 1'b1;
            BUSY     <= 1'b0;
          end else if (!FIFO_EMPTY) begin
            FIFO_RE <= 1'b1;
            lat_cnt <= '0;
            state   <= WAITQ;
          end
        end
        WAITQ: begin
          if (lat_cnt != LATW'(RD_LAT)) begin
            lat_cnt <= lat_cnt + LATW'(1);
          end else if (!ENABLE) begin
            state    <= IDLE;
            LCD_CS_N <= 1'b1;
            LCD_DC   <= 1'b1;
            BUSY     <= 1'b0;
          end else if (FIFO_Q[17]) begin
            // SOF starts a frame from HUNT, or aborts and restarts one mid-frame.
`ifdef LCD_SOF_ERR_CNT_EN
            if (!hunting && SOF_ERR_CNT != 8'hFF) SOF_ERR_CNT <= SOF_ERR_CNT + 8'd1;
`endif
            held     <= FIFO_Q[15:0];
            hunting  <= 1'b0;
            pix_cnt  <= '0;
            line_cnt <= '0;
            state    <= CMD;
            LCD_CS_N <= 1'b0;
            LCD_DC   <= 1'b0;
            LCD_D    <= 16'(CMD_MEMWR);
          end else if (hunting) begin
            state <= HUNT;
          end else begin
            state  <= PIX;
            LCD_DC <= 1'b1;
            LCD_D  <= FIFO_Q[15:0];
          end
        end
        CMD, PIX: begin
          state    <= WR_L;
          LCD_WR_N <= 1'b0;
          cyc_cnt  <= '0;
        end
        WR_L: begin
          if (cyc_cnt == CW'(WR_LOW_CYC - 1)) begin
            state    <= WR_H;
            LCD_WR_N <= 1'b1;
            cyc_cnt  <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        WR_H: begin
          if (cyc_cnt != CW'(WR_HIGH_CYC - 1)) begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end else if (!LCD_DC) begin
            // Command finished: the held SOF pixel goes out next.
            if (!ENABLE) begin
              state    <= IDLE;
              LCD_CS_N <= 1'b1;
              LCD_DC   <= 1'b1;
              BUSY     <= 1'b0;
            end else begin
              state  <= PIX;
              LCD_DC <= 1'b1;
              LCD_D  <= held;
            end
          end else if (pix_cnt == PW'(H_PIX - 1) && line_cnt == LW'(V_LINES - 1)) begin
            state      <= FDONE;
            FRAME_DONE <= 1'b1;
            LCD_CS_N   <= 1'b1;
            pix_cnt    <= '0;
            line_cnt   <= '0;
          end else begin
            if (pix_cnt == PW'(H_PIX - 1)) begin
              pix_cnt  <= '0;
              line_cnt <= line_cnt + LW'(1);
            end else begin
              pix_cnt <= pix_cnt + PW'(1);
            end
            if (!ENABLE) begin
              state    <= IDLE;
              LCD_CS_N <= 1'b1;
              BUSY     <= 1'b0;
            end else begin
              state <= FETCH;
            end
          end
        end
        FDONE: begin
          if (ENABLE) begin
            state   <= HUNT;
            hunting <= 1'b1;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          LCD_CS_N <= 1'b1;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_fifo_drain_ctrl.sv
// Bench for lcd_fifo_drain_ctrl: FIFO model, transaction-level expected write stream, protocol monitor.
module tb_lcd_fifo_drain_ctrl;

  localparam int unsigned H_PIX       = 4;
  localparam int unsigned V_LINES     = 2;
  localparam int unsigned WR_LOW_CYC  = 2;
  localparam int unsigned WR_HIGH_CYC = 2;
  localparam int unsigned RD_LAT      = 1;
  localparam int          FRAME_PIX   = int'(H_PIX * V_LINES);
  localparam int          EV_DAT      = 65536;
  localparam int          EV_DONE     = 2 * 65536;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        FIFO_EMPTY;
  logic [17:0] FIFO_Q;
  logic        FIFO_RE;
  logic        LCD_CS_N;
  logic        LCD_DC;
  logic        LCD_WR_N;
  logic [15:0] LCD_D;
  logic        FRAME_DONE;
  logic        BUSY;
`ifdef LCD_SOF_ERR_CNT_EN
  logic [7:0]  SOF_ERR_CNT;
`endif

  lcd_fifo_drain_ctrl #(
    .H_PIX(H_PIX), .V_LINES(V_LINES), .WR_LOW_CYC(WR_LOW_CYC),
    .WR_HIGH_CYC(WR_HIGH_CYC), .CMD_MEMWR(8'h2C), .RD_LAT(RD_LAT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_Q(FIFO_Q), .FIFO_RE(FIFO_RE), .LCD_CS_N(LCD_CS_N), .LCD_DC(LCD_DC),
    .LCD_WR_N(LCD_WR_N), .LCD_D(LCD_D), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
`ifdef LCD_SOF_ERR_CNT_EN
    , .SOF_ERR_CNT(SOF_ERR_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int          exp_q[$];
  logic [17:0] fq[$];
  logic [17:0] pipe[RD_LAT];
  // Behavioural model state: frame position in pixels and abort count.
  bit          m_hunt = 1'b1;
  int          m_cnt  = 0;
  int          m_err  = 0;
  // Monitor state.
  logic        prev_wr = 1'b1, prev_dc = 1'b1, prev_fd = 1'b0, lat_dc = 1'b1;
  logic [15:0] prev_d = '0, lat_d = '0;
  int          low_len = 0, high_len = 100, re_gap = 100;
  bit          last_cmd = 1'b0;
  bit          mon_on = 1'b1;
  int          n_writes = 0, n_done = 0, first_dat = -1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Expected LCD events for one popped word, from the frame rules.
  task automatic model_feed(input logic [17:0] w);
    if (w[17]) begin
      if (!m_hunt && m_err < 255) m_err++;
      exp_q.push_back(int'(8'h2C));
      exp_q.push_back(EV_DAT + int'(w[15:0]));
      m_cnt  = 1;
      m_hunt = 1'b0;
    end else if (!m_hunt) begin
      exp_q.push_back(EV_DAT + int'(w[15:0]));
      m_cnt++;
    end
    if (!m_hunt && m_cnt == FRAME_PIX) begin
      exp_q.push_back(EV_DONE);
      m_hunt = 1'b1;
      m_cnt  = 0;
    end
  endtask

  task automatic push(input logic sof, input logic [15:0] px);
    logic [17:0] w;
    w = {sof, 1'b0, px};
    fq.push_back(w);
    model_feed(w);
    FIFO_EMPTY = 1'b0;
  endtask

  task automatic monitor();
    int ev;
    if (RESET) begin
      prev_wr = 1'b1; prev_fd = 1'b0; low_len = 0; high_len = 100; re_gap = 100; last_cmd = 1'b0;
      return;
    end
    if (FIFO_RE) begin
      chk("re_not_empty", int'(FIFO_EMPTY), 0);
      chk("re_spacing", int'(re_gap > int'(RD_LAT)), 1);
      re_gap = 0;
    end else begin
      re_gap++;
    end
    if (!LCD_WR_N) begin
      if (prev_wr) begin
        chk("wr_setup", int'({LCD_DC, LCD_D}), int'({prev_dc, prev_d}));
        if (last_cmd) chk("cmd_pix_gap", high_len, int'(WR_HIGH_CYC) + 1);
        else chk("wr_high_min", int'(high_len >= int'(WR_HIGH_CYC) + 1), 1);
        lat_d = LCD_D; lat_dc = LCD_DC; low_len = 0;
      end else begin
        chk("wr_hold", int'({LCD_DC, LCD_D}), int'({lat_dc, lat_d}));
      end
      chk("cs_during_wr", int'(LCD_CS_N), 0);
      low_len++;
    end else begin
      if (!prev_wr) begin
        chk("wr_low_len", low_len, int'(WR_LOW_CYC));
        ev = (lat_dc ? EV_DAT : 0) + int'(lat_d);
        n_writes++;
        if (lat_dc && first_dat < 0) first_dat = int'(lat_d);
        last_cmd = !lat_dc;
        high_len = 0;
        if (mon_on) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL write_unexpected: got %0h want none", ev);
          end else begin
            chk("write", ev, exp_q.pop_front());
          end
        end
      end
      high_len++;
    end
    if (FRAME_DONE) begin
      chk("done_cs", int'(LCD_CS_N), 1);
      chk("done_single", int'(prev_fd), 0);
      n_done++;
      if (mon_on) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got pulse want none");
        end else begin
          chk("done_event", EV_DONE, exp_q.pop_front());
        end
      end
    end
    if (!BUSY) chk("idle_quiet", int'({LCD_CS_N, LCD_WR_N, FIFO_RE}), 6);
    prev_fd = FRAME_DONE; prev_wr = LCD_WR_N; prev_d = LCD_D; prev_dc = LCD_DC;
  endtask

  // One clock: synchronous FIFO update just after the edge, monitor on the falling edge.
  task automatic step();
    logic re_s;
    re_s = FIFO_RE;
    @(posedge CLK);
    #1;
    for (int i = int'(RD_LAT) - 1; i > 0; i--) pipe[i] = pipe[i-1];
    if (re_s && fq.size() > 0) pipe[0] = fq.pop_front();
    FIFO_Q = pipe[RD_LAT-1];
    FIFO_EMPTY = (fq.size() == 0);
    @(negedge CLK);
    monitor();
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && k < budget) begin
      step();
      k++;
    end
    repeat (4) step();
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic clear_bench();
    fq.delete(); exp_q.delete();
    m_hunt = 1'b1; m_cnt = 0; m_err = 0;
    for (int i = 0; i < int'(RD_LAT); i++) pipe[i] = '0;
    FIFO_EMPTY = 1'b1;
  endtask

  initial begin
    int k;
    logic [17:0] w;
    RESET = 1'b1; ENABLE = 1'b0; FIFO_EMPTY = 1'b1; FIFO_Q = '0;
    clear_bench();
    repeat (3) step();
    chk("rst_outputs", int'({FIFO_RE, LCD_CS_N, LCD_DC, LCD_WR_N, LCD_D, FRAME_DONE, BUSY}),
        int'({1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}));
    RESET = 1'b0;
    repeat (2) step();
    chk("idle_busy", int'(BUSY), 0);

    // Preloaded single frame; the literal checks pin the model.
    push(1'b1, 16'h0001);
    for (int i = 2; i <= 8; i++) push(1'b0, 16'(i));
    chk("model_len", exp_q.size(), 10);
    chk("model_cmd", exp_q[0], 'h2C);
    chk("model_pix0", exp_q[1], 'h10001);
    chk("model_done", exp_q[9], EV_DONE);
    ENABLE = 1'b1; n_writes = 0; n_done = 0;
    drain("t1", 400);
    chk("t1_writes", n_writes, 9);
    chk("t1_done", n_done, 1);

    // Leading words without SOF are discarded.
    n_writes = 0; first_dat = -1;
    repeat (3) push(1'b0, 16'hAAAA);
    push(1'b1, 16'h1111);
    for (int i = 1; i < 8; i++) push(1'b0, 16'h1111 + 16'(i));
    drain("t2", 400);
    chk("t2_first", first_dat, 'h1111);
    chk("t2_writes", n_writes, 9);

    // Mid-frame SOF at pixel 3 aborts and restarts.
    n_writes = 0; n_done = 0;
    push(1'b1, 16'h0100); push(1'b0, 16'h0101); push(1'b0, 16'h0102);
    push(1'b1, 16'h0200);
    for (int i = 1; i < 8; i++) push(1'b0, 16'h0200 + 16'(i));
    chk("model_err", m_err, 1);
    drain("t3", 500);
    chk("t3_done", n_done, 1);
    chk("t3_writes", n_writes, 13);
`ifdef LCD_SOF_ERR_CNT_EN
    chk("t3_err_cnt", int'(SOF_ERR_CNT), 1);
`endif

    // FIFO runs dry mid-line.
    push(1'b1, 16'h0300); push(1'b0, 16'h0301);
    drain("t4a", 200);
    repeat (10) begin
      step();
      chk("t4_stall", int'({FIFO_RE, LCD_WR_N, LCD_CS_N}), 2);
    end
    for (int i = 2; i < 8; i++) push(1'b0, 16'h0300 + 16'(i));
    drain("t4b", 400);

    // Asynchronous reset during a data write.
    push(1'b1, 16'h0400);
    for (int i = 1; i < 8; i++) push(1'b0, 16'h0400 + 16'(i));
    k = 0;
    while (!(!LCD_WR_N && LCD_DC) && k < 200) begin step(); k++; end
    chk("t5_reached_wr", int'(!LCD_WR_N && LCD_DC), 1);
    RESET = 1'b1;
    #1;
    chk("t5_async_rst", int'({FIFO_RE, LCD_CS_N, LCD_DC, LCD_WR_N, LCD_D, FRAME_DONE, BUSY}),
        int'({1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}));
    clear_bench();
    repeat (2) step();
`ifdef LCD_SOF_ERR_CNT_EN
    chk("t5_err_rst", int'(SOF_ERR_CNT), 0);
`endif
    RESET = 1'b0;
    step();
    chk("t5_hunt", int'({BUSY, LCD_CS_N}), 3);
    push(1'b1, 16'h0410);
    for (int i = 1; i < 8; i++) push(1'b0, 16'h0410 + 16'(i));
    drain("t5", 400);

    // ENABLE dropped during the low phase of pixel 5.
    push(1'b1, 16'h0500);
    for (int i = 1; i < 8; i++) push(1'b0, 16'h0500 + 16'(i));
    k = 0;
    while (!(!LCD_WR_N && LCD_DC && LCD_D == 16'h0505) && k < 300) begin step(); k++; end
    chk("t6_reached_px5", int'(LCD_D), 'h0505);
    ENABLE = 1'b0;
    k = 0;
    while (!LCD_WR_N && k < 20) begin step(); k++; end
    chk("t6_fifo_left", fq.size(), 2);
    exp_q.delete();
    k = 0;
    while (!(!BUSY && LCD_CS_N) && k < 20) begin step(); k++; end
    chk("t6_idle_lat", int'(k <= int'(WR_HIGH_CYC) + 1), 1);
    repeat (10) begin
      step();
      chk("t6_no_re", int'(FIFO_RE), 0);
    end
    m_hunt = 1'b1; m_cnt = 0;
    foreach (fq[i]) model_feed(fq[i]);
    ENABLE = 1'b1;

    // Randomised stream with sparse SOF tags and irregular arrivals.
    for (int i = 0; i < 600; i++) begin
      if (fq.size() < 60 && $urandom_range(0, 2) == 0) begin
        w = {($urandom_range(0, 5) == 0), 1'($urandom), 16'($urandom)};
        fq.push_back(w);
        model_feed(w);
        FIFO_EMPTY = 1'b0;
      end
      step();
    end
    drain("rand", 4000);
`ifdef LCD_SOF_ERR_CNT_EN
    chk("rand_err_cnt", int'(SOF_ERR_CNT), m_err);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_fifo_drain_ctrl.md
Name: lcd_fifo_drain_ctrl

Overview:
- Read-side sequencer for the 64x18 synchronous pixel FIFO between the OV7725 capture path and the LCD.
- Pops RGB565 words from the FIFO and drives 8080-style LCD write cycles (CS_N/DC/WR_N/D[15:0]).
- Opens every frame with a memory-write command and counts pixels and lines; FRAME_DONE pulses at frame end.
- Resynchronises on the start-of-frame tag carried in FIFO bit 17.

Parameters:
H_PIX, 320, pixels per line (>=1)
V_LINES, 240, lines per frame (>=1)
WR_LOW_CYC, 2, CLK cycles WR_N held low per write (>=1)
WR_HIGH_CYC, 2, CLK cycles WR_N held high after each write (>=1)
CMD_MEMWR, 8'h2C, command byte sent at frame start, zero-extended to 16 bits
RD_LAT, 1, CLK cycles from FIFO_RE asserted to FIFO_Q valid (1..3)

Ports:
CLK  in  1  single system clock, rising edge
RESET  in  1  asynchronous, active-high reset
ENABLE  in  1  level; 0 = finish current write cycle then return to IDLE
FIFO_EMPTY  in  1  FIFO EMPTY flag
FIFO_Q  in  18  FIFO read data: [17]=SOF tag, [16]=ignored, [15:0]=RGB565
FIFO_RE  out  1  FIFO read enable, active-high
LCD_CS_N  out  1  LCD chip select, active-low
LCD_DC  out  1  0=command, 1=data
LCD_WR_N  out  1  LCD write strobe, active-low
LCD_D  out  16  LCD data bus
FRAME_DONE  out  1  one-cycle pulse after last pixel of a frame
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset values: FIFO_RE=0, LCD_CS_N=1, LCD_DC=1, LCD_WR_N=1, LCD_D=0, FRAME_DONE=0, BUSY=0. Counters cleared. State=IDLE. All outputs are registered.
- Interface: single clock; reset is asynchronous and active-high (ports CLK and RESET).
- FIFO_RE is asserted only when FIFO_EMPTY=0, and for exactly one cycle per word. Never more than one read outstanding.
- Data is captured RD_LAT cycles after FIFO_RE.
- States:
  - IDLE: ENABLE=1 -> HUNT.
  - HUNT: pop words and discard until a word with SOF=1 is captured. Hold that pixel -> CMD.
  - CMD: CS_N=0, DC=0, D=CMD_MEMWR -> WR_L.
  - WR_L: WR_N=0 for WR_LOW_CYC cycles -> WR_H.
  - WR_H: WR_N=1 for WR_HIGH_CYC cycles.
    - After the command: -> PIX, using the held pixel.
    - After a pixel: advance counters. Frame complete -> FDONE; otherwise -> FETCH.
  - FETCH: wait while EMPTY=1 (CS_N stays 0, WR_N=1). Pulse RE -> WAITQ.
  - WAITQ: count RD_LAT cycles, capture FIFO_Q.
    - SOF=1 mid-frame: abort the frame, clear counters, hold the word -> CMD. No FRAME_DONE.
    - SOF=0: -> PIX.
  - PIX: DC=1, D=held[15:0] -> WR_L.
  - FDONE: FRAME_DONE=1 for one cycle, CS_N=1. ENABLE=1 -> HUNT; else -> IDLE.
- Counters:
  - pix_cnt runs 0..H_PIX-1; at H_PIX-1 it wraps to 0 and line_cnt increments.
  - The frame completes when pix_cnt=H_PIX-1 and line_cnt=V_LINES-1 at the end of WR_H.
  - Counter widths are $clog2 of the parameter, minimum 1.
- LCD_D and LCD_DC are stable from one cycle before WR_N falls until WR_N rises.
- ENABLE deasserted:
  - During HUNT/FETCH with no read outstanding: -> IDLE next cycle, CS_N=1.
  - During a write or a pending read: complete that write or capture first, then go to IDLE. The captured word is discarded.
- RESET mid-write: outputs return to reset values immediately. Popped data is lost; the next frame starts with HUNT.
- A word with SOF=1 as the first pixel after CMD is normal, not an abort.

Optional Feature:
- Macro: LCD_SOF_ERR_CNT_EN.
- Defined:
  - Adds output SOF_ERR_CNT[7:0], reset 0.
  - Increments on each mid-frame SOF abort and saturates at 8'hFF.
  - Cleared only by RESET.
- Undefined: the port and the counter are absent. Abort behaviour is identical either way.

Test Plan:
1. H_PIX=4, V_LINES=2, FIFO preloaded SOF+0x0001..0x0008, ENABLE=1 -> one command write 0x002C with DC=0, then 8 data writes 0x0001..0x0008 with DC=1; exactly one FRAME_DONE pulse; WR_N low for 2 cycles and high for 2 cycles on each write.
2. Three words without SOF (0xAAAA), then SOF+0x1111 -> the 0xAAAA words are popped and never written; first data write is 0x1111.
3. SOF at pixel 3 of 8 -> frame aborted with no FRAME_DONE; new command 0x002C; that word is written as pixel 0; SOF_ERR_CNT=1 when the macro is defined.
4. FIFO_EMPTY=1 for 10 cycles mid-line -> FIFO_RE=0 and WR_N=1 throughout, CS_N stays 0; streaming resumes correctly with no duplicated or dropped pixels.
5. RESET pulsed while WR_N=0 -> all outputs reach reset values asynchronously within the same cycle; after release with ENABLE=1 the block enters HUNT.
6. ENABLE dropped during WR_L of pixel 5 -> that write completes, CS_N=1, BUSY=0 within WR_HIGH_CYC+1 cycles, and no further FIFO_RE.
